// File: rtl/mmu09_pkg.sv
// Shared definitions for the MMU09 clock generator and its users.
// Phase encoding is {Q,E} so the outputs are plain state register bits.
package mmu09_pkg;

   typedef enum logic [1:0] {
      EF = 2'b00,
      QR = 2'b10,
      ER = 2'b11,
      QF = 2'b01
   } phase_t;

   localparam int RESET_CYCLES_DEF = 16;
   localparam int MAX_STRETCH_DEF  = 8;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mmu09_clkgen_if.sv
// Clock/reset bundle between the clock generator and the SBC logic.
// master drives the clocks, slave supplies memory ready.
interface mmu09_clkgen_if;

   logic mrdy;
   logic qclk;
   logic eclk;
   logic cpu_reset_n;
   logic bus_end;
   logic stretching;

   modport master (
      input  mrdy,
      output qclk,
      output eclk,
      output cpu_reset_n,
      output bus_end,
      output stretching
   );

   modport slave (
      output mrdy,
      input  qclk,
      input  eclk,
      input  cpu_reset_n,
      input  bus_end,
      input  stretching
   );

endinterface

// File: rtl/mmu09_porst.sv
// Power-on reset sequencer: releases the CPU on an E falling edge
// once enough clk edges have elapsed since board reset release.
module mmu09_porst
   import mmu09_pkg::*;
#(
   parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ev,
   output logic cpu_reset_n
);

   localparam int CW = cnt_width(RESET_CYCLES);
   localparam logic [CW-1:0] SAT = CW'(RESET_CYCLES);

   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_inc;
   logic          sat_now;

   // saturation counts the edge being taken, so ev on edge N can release
   assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
   assign sat_now = (cnt == SAT) || (cnt_inc >= {1'b0, SAT});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         cpu_reset_n <= 1'b0;
      end else begin
         if (cnt != SAT) begin
            cnt <= cnt + CW'(1);
         end
         if (ev && sat_now) begin
            cpu_reset_n <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmu09_clkgen.sv
// 6809 Q/E clock generator with E-high stretching on memory not-ready
// and a power-on CPU reset aligned to the E falling edge.
module mmu09_clkgen
   import mmu09_pkg::*;
#(
   parameter int RESET_CYCLES = RESET_CYCLES_DEF,
   parameter int MAX_STRETCH  = MAX_STRETCH_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   mmu09_clkgen_if.master bus
);

   localparam int SW = cnt_width(MAX_STRETCH);
   localparam logic [SW-1:0] SMAX = SW'(MAX_STRETCH);

   phase_t        state;
   phase_t        state_nx;
   logic [SW-1:0] scnt;
   logic [SW-1:0] scnt_nx;
   logic          hold;
   logic          e_fall;
   logic          be_q;
   logic          st_q;
   logic          cpu_rst_n;

   always_comb begin
      state_nx = state;
      scnt_nx  = scnt;
      hold     = 1'b0;
      e_fall   = 1'b0;
      unique case (state)
         EF: state_nx = QR;
         QR: state_nx = ER;
         ER: state_nx = QF;
         QF: begin
            if (!bus.mrdy && (scnt < SMAX)) begin
               hold    = 1'b1;
               scnt_nx = scnt + SW'(1);
            end else begin
               state_nx = EF;
               scnt_nx  = '0;
               e_fall   = 1'b1;
            end
         end
         default: state_nx = EF;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EF;
         scnt  <= '0;
         be_q  <= 1'b0;
         st_q  <= 1'b0;
      end else begin
         state <= state_nx;
         scnt  <= scnt_nx;
         be_q  <= e_fall;
         st_q  <= hold;
      end
   end

   mmu09_porst #(
      .RESET_CYCLES(RESET_CYCLES)
   ) u_porst (
      .clk        (clk),
      .reset_n    (reset_n),
      .ev         (e_fall),
      .cpu_reset_n(cpu_rst_n)
   );

   assign bus.qclk        = state[1];
   assign bus.eclk        = state[0];
   assign bus.bus_end     = be_q;
   assign bus.stretching  = st_q;
   assign bus.cpu_reset_n = cpu_rst_n;

endmodule

// File: tb/tb_mmu09_clkgen.sv
// Scoreboard bench: stimulus queues one expected E cycle per issued
// cycle, monitors check Q/E/stretching/bus_end/cpu_reset_n per clk.
module tb_mmu09_clkgen;
   import mmu09_pkg::*;

   localparam int RC1 = 4;

   typedef struct {
      int   n;
      logic rd;
      logic re;
   } exp_t;

   logic clk;
   logic reset_n;
   logic rst1_n;

   int checks;
   int errors;
   exp_t q0[$];
   exp_t q1[$];
   int ec0, ec1, last0, last1, pos0, pos1;
   bit mon0_en, mon1_en;
   int edges0;
   logic rst_st0;

   mmu09_clkgen_if b0();
   mmu09_clkgen_if b1();

   mmu09_clkgen u0 (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (b0.master)
   );

   mmu09_clkgen #(
      .RESET_CYCLES(RC1),
      .MAX_STRETCH (0)
   ) u1 (
      .clk    (clk),
      .reset_n(rst1_n),
      .bus    (b1.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [4:0] act,
                      input logic [4:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", nm, act, req);
      end
   endtask

   // expected {q,e,stretching,bus_end,cpu_reset_n} at offset pos
   function automatic logic [4:0] exp_vec(input exp_t x, input int pos);
      logic [1:0] qe;
      logic st, be, cr;
      int lst;
      lst = 4 + x.n;
      if (pos == 0)        qe = 2'b00;
      else if (pos == 1)   qe = 2'b10;
      else if (pos == 2)   qe = 2'b11;
      else if (pos < lst)  qe = 2'b01;
      else                 qe = 2'b00;
      st = (pos >= 4) && (pos < lst);
      be = (pos == lst);
      cr = be ? x.re : x.rd;
      return {qe, st, be, cr};
   endfunction

   always @(posedge clk or negedge reset_n)
      if (!reset_n) ec0 <= 0;
      else          ec0 <= ec0 + 1;

   always @(posedge clk or negedge rst1_n)
      if (!rst1_n) ec1 <= 0;
      else         ec1 <= ec1 + 1;

   always @(negedge clk) begin
      if (!reset_n) begin
         last0 = 0;
      end else if (mon0_en) begin
         pos0 = ec0 - last0;
         if (q0.size() == 0) begin
            chk("u0_idle_bus_end", {4'b0, b0.bus_end}, 5'b0);
         end else begin
            chk($sformatf("u0_pos%0d_n%0d", pos0, q0[0].n),
                {b0.qclk, b0.eclk, b0.stretching,
                 b0.bus_end, b0.cpu_reset_n},
                exp_vec(q0[0], pos0));
            if (pos0 >= 4 + q0[0].n) begin
               void'(q0.pop_front());
               last0 = ec0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst1_n) begin
         last1 = 0;
      end else if (mon1_en) begin
         pos1 = ec1 - last1;
         if (q1.size() == 0) begin
            chk("u1_idle_bus_end", {4'b0, b1.bus_end}, 5'b0);
         end else begin
            chk($sformatf("u1_pos%0d", pos1),
                {b1.qclk, b1.eclk, b1.stretching,
                 b1.bus_end, b1.cpu_reset_n},
                exp_vec(q1[0], pos1));
            if (pos1 >= 4 + q1[0].n) begin
               void'(q1.pop_front());
               last1 = ec1;
            end
         end
      end
   end

   // mode: 0 = mrdy high before QF, 1 = toggling, 2 = held low
   task automatic run_cycle0(input int n, input int mode, input bit hold);
      exp_t x;
      int tot;
      tot  = edges0 + 4 + n;
      x.n  = n;
      x.rd = rst_st0;
      x.re = rst_st0 | (tot >= RESET_CYCLES_DEF);
      q0.push_back(x);
      rst_st0 = x.re;
      edges0  = tot;
      for (int e = 1; e <= 4 + n; e++) begin
         if (e <= 3) begin
            if (mode == 1)      b0.mrdy = ~e[0];
            else if (mode == 2) b0.mrdy = 1'b0;
            else                b0.mrdy = 1'b1;
         end else if (e < 4 + n) begin
            b0.mrdy = 1'b0;
         end else begin
            b0.mrdy = hold ? 1'b0 : 1'b1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic thread0();
      for (int i = 0; i < 4; i++) run_cycle0(0, 0, 0);
      run_cycle0(0, 1, 0);
      run_cycle0(0, 1, 0);
      run_cycle0(3, 0, 0);
      run_cycle0(0, 0, 0);
      run_cycle0(MAX_STRETCH_DEF, 2, 1);
      run_cycle0(MAX_STRETCH_DEF, 2, 1);
      run_cycle0(0, 1, 0);
      run_cycle0(1, 1, 0);
      run_cycle0(5, 0, 0);
      run_cycle0(MAX_STRETCH_DEF, 0, 0);
      // partial cycle, reset lands two clocks into the stretch
      for (int e = 1; e <= 5; e++) begin
         b0.mrdy = (e <= 3);
         @(posedge clk);
         #1;
      end
      chk("u0_pre_abort_stretch", {4'b0, b0.stretching}, 5'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("u0_abort_async",
          {b0.qclk, b0.eclk, b0.stretching, b0.bus_end, b0.cpu_reset_n},
          5'b0);
      @(posedge clk);
      #1;
      chk("u0_abort_held",
          {b0.qclk, b0.eclk, b0.stretching, b0.bus_end, b0.cpu_reset_n},
          5'b0);
      reset_n = 1'b1;
      rst_st0 = 1'b0;
      edges0  = 0;
      for (int i = 0; i < 4; i++) run_cycle0(0, 1, 0);
      run_cycle0(2, 0, 0);
      run_cycle0(0, 0, 0);
      @(negedge clk);
      #1;
      chk("u0_queue_drained", 5'(q0.size()), 5'd0);
      mon0_en = 1'b0;
   endtask

   task automatic thread1();
      exp_t x;
      for (int k = 0; k < 10; k++) begin
         x.n  = 0;
         x.rd = (4 * k >= RC1);
         x.re = (4 * (k + 1) >= RC1);
         q1.push_back(x);
         repeat (4) @(posedge clk);
      end
      @(negedge clk);
      #1;
      chk("u1_queue_drained", 5'(q1.size()), 5'd0);
      mon1_en = 1'b0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      mon0_en = 1'b0;
      mon1_en = 1'b0;
      edges0  = 0;
      rst_st0 = 1'b0;
      reset_n = 1'b0;
      rst1_n  = 1'b0;
      b0.mrdy = 1'b1;
      b1.mrdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("u0_reset",
          {b0.qclk, b0.eclk, b0.stretching, b0.bus_end, b0.cpu_reset_n},
          5'b0);
      chk("u1_reset",
          {b1.qclk, b1.eclk, b1.stretching, b1.bus_end, b1.cpu_reset_n},
          5'b0);
      reset_n = 1'b1;
      rst1_n  = 1'b1;
      mon0_en = 1'b1;
      mon1_en = 1'b1;
      fork
         thread0();
         thread1();
      join
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
